spi_slave: RTL and testbench

SPI responder for the SPI master block: a full-duplex, parameterised-width SPI slave that samples the master's SCLK, ss and MOSI in the local clock domain. It shifts a parallel word out on MISO while shifting a word in from MOSI. It supports all four SPI modes, back-to-back words within one ss assertion and mid-word frame abort. It sits on the peripheral side of the link, between the SPI pins and a local register/FIFO interface.

---
 rtl/spi_slave_if.sv | 27 ++
 rtl/spi_slave.sv | 165 ++++++++++++++++
 tb/tb_spi_slave.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Pin-side and local-side signals of the SPI responder, with the SPI slave
// (DUT) and the SPI master / local host views as modports.
interface spi_slave_if #(
  parameter int bits_size = 8
);
  logic                 SCLK;
  logic                 ss;
  logic                 MOSI;
  logic                 MISO;
  logic                 miso_en;
  logic [bits_size-1:0] data_in;
  logic [bits_size-1:0] data_out;
  logic                 tx_load;
  logic                 rx_done;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  SCLK, ss, MOSI, data_in,
    output MISO, miso_en, data_out, tx_load, rx_done, frame_err, busy
  );

  modport master (
    output SCLK, ss, MOSI, data_in,
    input  MISO, miso_en, data_out, tx_load, rx_done, frame_err, busy
  );
endinterface

// File: rtl/spi_slave.sv
// Full-duplex SPI slave, all four modes, sampled in the local clk domain.
// Supports back-to-back words under one ss assertion and mid-word abort.
module spi_slave #(
  parameter logic [1:0] mode      = 2'b00,
  parameter int         bits_size = 8
) (
  input logic       clk,
  input logic       reset_n,
  spi_slave_if.slave bus
);
  localparam logic CPOL = mode[1];
  localparam logic CPHA = mode[0];
  localparam int   CW   = (bits_size > 2) ? $clog2(bits_size) : 1;
  localparam logic [CW-1:0] LAST = CW'(bits_size - 1);
  localparam int   MSB  = bits_size - 1;

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [2:0]           sclk_sync_q, sclk_sync_d;
  logic [2:0]           ss_sync_q, ss_sync_d;
  logic [1:0]           mosi_sync_q, mosi_sync_d;
  logic [bits_size-1:0] tx_sh_q, tx_sh_d;
  logic [bits_size-1:0] rx_sh_q, rx_sh_d;
  logic [bits_size-1:0] data_out_q, data_out_d;
  logic [bits_size-1:0] rx_word;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 miso_q, miso_d;
  logic                 skip_q, skip_d;
  logic                 tx_load_q, tx_load_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, drive_edge, ss_fall, ss_rise;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], bus.SCLK};
    ss_sync_d   = {ss_sync_q[1:0], bus.ss};
    mosi_sync_d = {mosi_sync_q[0], bus.MOSI};
  end

  // Stage [1] is the synchronised level, stage [2] its previous value.
  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign drive_edge  = CPHA ? lead_edge : trail_edge;
  assign ss_fall     = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    data_out_d  = data_out_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    skip_d      = skip_q;
    tx_load_d   = 1'b0;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    rx_word     = {rx_sh_q[bits_size-2:0], mosi_sync_q[1]};
    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = LAST;
        skip_d    = 1'b0;
        if (ss_fall) begin
          tx_load_d = 1'b1;
          tx_sh_d   = bus.data_in;
          if (!CPHA) miso_d = bus.data_in[MSB];
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          frame_err_d = (bit_cnt_q != LAST);
          miso_d      = 1'b0;
          bit_cnt_d   = LAST;
        end else if (sample_edge) begin
          rx_sh_d = rx_word;
          if (bit_cnt_q == '0) begin
            data_out_d = rx_word;
            rx_done_d  = 1'b1;
            bit_cnt_d  = LAST;
            tx_load_d  = 1'b1;
            tx_sh_d    = bus.data_in;
            // CPHA=0 presents the next MSB now, so the following drive edge must not shift.
            if (!CPHA) begin
              miso_d = bus.data_in[MSB];
              skip_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - CW'(1);
          end
        end else if (drive_edge) begin
          if (CPHA) begin
            miso_d  = tx_sh_q[MSB];
            tx_sh_d = tx_sh_q << 1;
          end else if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            miso_d  = tx_sh_q[MSB-1];
            tx_sh_d = tx_sh_q << 1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= {3{CPOL}};
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      data_out_q  <= '0;
      bit_cnt_q   <= LAST;
      miso_q      <= 1'b0;
      skip_q      <= 1'b0;
      tx_load_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      data_out_q  <= data_out_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      skip_q      <= skip_d;
      tx_load_q   <= tx_load_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Shift registers are fully reloaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  assign bus.MISO      = miso_q;
  assign bus.miso_en   = (state_q == ACTIVE);
  assign bus.busy      = (state_q == ACTIVE);
  assign bus.data_out  = data_out_q;
  assign bus.tx_load   = tx_load_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one DUT per SPI mode driven by a shared SPI master
// model; only the DUT matching the current mode is scored.
module tb_spi_slave;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset_n, sclk, ss, mosi;
  logic [7:0] din;

  logic [3:0] miso_w, men_w, txl_w, rxd_w, ferr_w, busy_w;
  logic [7:0] dout_w [4];

  int cur_mode = 0;
  int n_cmp = 0, n_fail = 0;
  int rx_cnt = 0, tl_cnt = 0, fe_cnt = 0, bad_co = 0;
  logic [7:0] got_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_m
    localparam logic CPOL_G = (g >= 2);
    spi_slave_if #(.bits_size(8)) bus ();
    assign bus.SCLK    = sclk ^ CPOL_G;
    assign bus.ss      = ss;
    assign bus.MOSI    = mosi;
    assign bus.data_in = din;
    assign miso_w[g]   = bus.MISO;
    assign men_w[g]    = bus.miso_en;
    assign txl_w[g]    = bus.tx_load;
    assign rxd_w[g]    = bus.rx_done;
    assign ferr_w[g]   = bus.frame_err;
    assign busy_w[g]   = bus.busy;
    assign dout_w[g]   = bus.data_out;
    spi_slave #(.mode(2'(g)), .bits_size(8)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );
  end

  // Pulse monitor for the DUT under test; received words are logged at rx_done.
  always @(negedge clk) begin
    if (rxd_w[cur_mode]) begin
      rx_cnt <= rx_cnt + 1;
      got_q.push_back(dout_w[cur_mode]);
      if (!txl_w[cur_mode]) bad_co <= bad_co + 1;
    end
    if (txl_w[cur_mode])  tl_cnt <= tl_cnt + 1;
    if (ferr_w[cur_mode]) fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] q_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  task automatic ss_low();
    ss = 1'b0;
    wait_clk(H);
    chk("busy_on", 32'(busy_w[cur_mode]), 1);
    chk("miso_en_on", 32'(men_w[cur_mode]), 1);
    chk("miso_load", 32'(miso_w[cur_mode]), cur_mode[0] ? 0 : 32'(din[7]));
  endtask

  task automatic ss_high();
    wait_clk(H);
    ss = 1'b1;
    wait_clk(8);
  endtask

  // Master side of one word (or its first nbits); next_din is queued after the first bit.
  task automatic send_word(input logic [7:0] w, input int nbits, input logic [7:0] next_din,
                           output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (cur_mode[0] == 1'b0) begin
        mosi = w[i];
        wait_clk(H);
        r[i] = miso_w[cur_mode];
        sclk = 1'b1;
        wait_clk(H);
        sclk = 1'b0;
      end else begin
        sclk = 1'b1;
        mosi = w[i];
        wait_clk(H);
        r[i] = miso_w[cur_mode];
        sclk = 1'b0;
        wait_clk(H);
      end
      if (i == 7) din = next_din;
    end
  endtask

  task automatic frame(input logic [7:0] m0, m1, s0, s1, input int nw);
    int rx0, tl0, fe0;
    logic [7:0] r0, r1;
    rx0 = rx_cnt; tl0 = tl_cnt; fe0 = fe_cnt; r1 = '0;
    got_q.delete();
    din = s0;
    ss_low();
    send_word(m0, 8, s1, r0);
    if (nw == 2) send_word(m1, 8, s1, r1);
    ss_high();
    chk("rx_done_cnt", rx_cnt - rx0, nw);
    chk("tx_load_cnt", tl_cnt - tl0, nw + 1);
    chk("frame_err_cnt", fe_cnt - fe0, 0);
    chk("master_rx0", 32'(r0), 32'(s0));
    chk("slave_rx0", 32'(q_at(0)), 32'(m0));
    if (nw == 2) begin
      chk("master_rx1", 32'(r1), 32'(s1));
      chk("slave_rx1", 32'(q_at(1)), 32'(m1));
    end
    chk("data_out_hold", 32'(dout_w[cur_mode]), 32'((nw == 2) ? m1 : m0));
  endtask

  initial begin
    int rx0, tl0, fe0, any_miso, any_en;
    logic [7:0] r;
    reset_n = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; din = '0;
    wait_clk(3);
    chk("reset_outs", 32'({miso_w[0], men_w[0], txl_w[0], rxd_w[0], ferr_w[0], busy_w[0]}), 0);
    chk("reset_dout", 32'(dout_w[0]), 0);
    reset_n = 1'b1;
    wait_clk(5);

    for (int m = 0; m < 4; m++) begin
      cur_mode = m;
      frame(8'h3C, 8'h00, 8'hA5, 8'h00, 1);
    end

    cur_mode = 0;
    frame(8'h18, 8'hE7, 8'h81, 8'h7E, 2);
    frame(8'h3C, 8'h00, 8'hA5, 8'h00, 1);

    // Abort after 4 SCLK cycles.
    rx0 = rx_cnt; fe0 = fe_cnt;
    din = 8'hC3;
    ss_low();
    send_word(8'h55, 4, 8'hC3, r);
    wait_clk(H);
    ss = 1'b1;
    wait_clk(4);
    chk("abort_miso_en", 32'(men_w[0]), 0);
    wait_clk(6);
    chk("abort_frame_err", fe_cnt - fe0, 1);
    chk("abort_no_rx", rx_cnt - rx0, 0);
    chk("abort_dout_kept", 32'(dout_w[0]), 32'h3C);
    chk("abort_miso", 32'(miso_w[0]), 0);
    frame(8'hE1, 8'h00, 8'h1E, 8'h00, 1);

    // Reset in the middle of a mode-3 word.
    cur_mode = 3;
    frame(8'h96, 8'h00, 8'h69, 8'h00, 1);
    rx0 = rx_cnt; tl0 = tl_cnt; fe0 = fe_cnt;
    din = 8'hF0;
    ss_low();
    send_word(8'hFF, 3, 8'hF0, r);
    reset_n = 1'b0;
    #1;
    chk("rst_outs", 32'({miso_w[3], men_w[3], txl_w[3], rxd_w[3], ferr_w[3], busy_w[3]}), 0);
    chk("rst_dout", 32'(dout_w[3]), 0);
    ss = 1'b1; mosi = 1'b0;
    wait_clk(5);
    reset_n = 1'b1;
    wait_clk(5);
    chk("rst_no_pulses", (rx_cnt - rx0) + (tl_cnt - tl0) + (fe_cnt - fe0), 1);
    frame(8'h5A, 8'h00, 8'hC6, 8'h00, 1);

    // SCLK toggling while deselected.
    cur_mode = 0;
    rx0 = rx_cnt; tl0 = tl_cnt; fe0 = fe_cnt; any_miso = 0; any_en = 0;
    for (int i = 0; i < 8; i++) begin
      mosi = 1'($urandom);
      sclk = 1'b1;
      wait_clk(H);
      any_miso |= int'(miso_w[0]); any_en |= int'(men_w[0]);
      sclk = 1'b0;
      wait_clk(H);
      any_miso |= int'(miso_w[0]); any_en |= int'(men_w[0]);
    end
    chk("idle_sclk_pulses", (rx_cnt - rx0) + (tl_cnt - tl0) + (fe_cnt - fe0), 0);
    chk("idle_sclk_miso", any_miso, 0);
    chk("idle_sclk_en", any_en, 0);

    for (int m = 0; m < 4; m++) begin
      cur_mode = m;
      for (int k = 0; k < 2; k++)
        frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(2, 1)));
    end

    chk("rx_tx_coincide", bad_co, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

●
